// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator controller front end.
//   NUM_FLOORS/FLOOR_W : floor count and floor-number width
//   NUM_CALLS/CALL_W   : size of the combined up/down call vector and its index width
//   CALL_MASK          : calls that physically exist (no down at floor 0, no up at floor 7)
//   scan_state_t       : hall-call scanner FSM states
package elevator_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 3;
  localparam int NUM_CALLS  = 2 * NUM_FLOORS;
  localparam int CALL_W     = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Index i<8 is the up call at floor i, index i>=8 the down call at floor i-8.
  localparam logic [NUM_CALLS-1:0] CALL_MASK = 16'hFE7F;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLDOFF
  } scan_state_t;

  function automatic logic call_dir(input logic [CALL_W-1:0] idx);
    return idx[CALL_W-1] ? DIR_DOWN : DIR_UP;
  endfunction

  function automatic logic [FLOOR_W-1:0] call_floor(input logic [CALL_W-1:0] idx);
    return idx[FLOOR_W-1:0];
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One hall-call button: 2-flop synchronizer, 3-sample history taken on the
// shared tick, hysteretic debounced level and a one-cycle press pulse.
//   clk, reset : system clock, synchronous active-high reset
//   tick       : shared sample strobe
//   btn_raw    : asynchronous raw button, active-high
//   press      : one-cycle pulse on the 0->1 transition of the debounced level
module button_debouncer (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_raw,
  output logic press
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [2:0] hist_q,  hist_d;
  logic       level_q, level_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    hist_d  = hist_q;
    level_d = level_q;
    if (tick) begin
      hist_d = {hist_q[1:0], sync2_q};
      if (hist_d == 3'b111) begin
        level_d = 1'b1;
      end else if (hist_d == 3'b000) begin
        level_d = 1'b0;
      end
    end
    // Pulse coincides with the tick that raises the level.
    press = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/hall_call_scanner.sv
// Hall-call scanner: debounces 8 up and 8 down hall buttons, latches new
// presses as pending calls and serializes them, round-robin, into
// single-cycle request strobes separated by a fixed idle gap.
//   SAMPLE_CYCLES : clock cycles between debounce samples (>=2)
//   GAP_CYCLES    : idle cycles forced after each issued request (>=1)
//   clk, reset    : system clock, synchronous active-high reset
//   btn_up/down   : raw asynchronous buttons, bit i = floor i
//   valid_out     : one-cycle request strobe
//   req_floor     : floor of the request (held while valid_out=0)
//   direction     : 1 = up, 0 = down (held while valid_out=0)
//   pending_up/down : latched, not-yet-issued calls
module hall_call_scanner
  import elevator_pkg::*;
#(
  parameter int unsigned SAMPLE_CYCLES = 1_000_000,
  parameter int unsigned GAP_CYCLES    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn_up,
  input  logic [NUM_FLOORS-1:0] btn_down,
  output logic                  valid_out,
  output logic [FLOOR_W-1:0]    req_floor,
  output logic                  direction,
  output logic [NUM_FLOORS-1:0] pending_up,
  output logic [NUM_FLOORS-1:0] pending_down
);

  localparam int TICK_W = $clog2(SAMPLE_CYCLES);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic                 tick;
  logic [NUM_CALLS-1:0] raw_vec;
  logic [NUM_CALLS-1:0] press_vec;
  logic [NUM_CALLS-1:0] pending_q, pending_d;
  logic [NUM_CALLS-1:0] clr_vec;
  scan_state_t          state_q, state_d;
  logic [CALL_W-1:0]    ptr_q, ptr_d;
  logic [CALL_W-1:0]    grant_q, grant_d;
  logic [FLOOR_W-1:0]   req_floor_q, req_floor_d;
  logic                 direction_q, direction_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 found;
  logic [CALL_W-1:0]    pick_idx;
  logic [CALL_W-1:0]    scan_idx;

  // Shared sample tick.
  always_comb begin
    tick       = (tick_cnt_q == TICK_W'(SAMPLE_CYCLES - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  assign raw_vec = {btn_down, btn_up};

  // Nonexistent calls get a debouncer whose input is tied low.
  for (genvar i = 0; i < NUM_CALLS; i++) begin : g_btn
    button_debouncer u_deb (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .btn_raw (raw_vec[i] & CALL_MASK[i]),
      .press   (press_vec[i])
    );
  end

  // Round-robin search starting at ptr; wraps naturally in 4 bits.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NUM_CALLS; i++) begin
      scan_idx = ptr_q + CALL_W'(i);
      if (!found && pending_q[scan_idx]) begin
        found    = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    req_floor_d = req_floor_q;
    direction_d = direction_q;
    gap_d       = gap_q;
    clr_vec     = '0;
    valid_out   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d     = pick_idx;
          req_floor_d = call_floor(pick_idx);
          direction_d = call_dir(pick_idx);
          ptr_d       = pick_idx + 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        valid_out        = 1'b1;
        clr_vec[grant_q] = 1'b1;
        gap_d            = '0;
        state_d          = HOLDOFF;
      end
      HOLDOFF: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A press landing on the clear cycle keeps the call pending.
    pending_d = (pending_q & ~clr_vec) | press_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      pending_q   <= '0;
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      req_floor_q <= '0;
      direction_q <= 1'b0;
      gap_q       <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      req_floor_q <= req_floor_d;
      direction_q <= direction_d;
      gap_q       <= gap_d;
    end
  end

  assign req_floor    = req_floor_q;
  assign direction    = direction_q;
  assign pending_up   = pending_q[NUM_FLOORS-1:0];
  assign pending_down = pending_q[NUM_CALLS-1:NUM_FLOORS];

endmodule

// File: tb/tb_hall_call_scanner.sv
module tb_hall_call_scanner;

  logic       clk;
  logic       reset;
  logic [7:0] btn_up;
  logic [7:0] btn_down;
  logic       valid_out;
  logic [2:0] req_floor;
  logic       direction;
  logic [7:0] pending_up;
  logic [7:0] pending_down;

  hall_call_scanner #(
    .SAMPLE_CYCLES (4),
    .GAP_CYCLES    (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .valid_out    (valid_out),
    .req_floor    (req_floor),
    .direction    (direction),
    .pending_up   (pending_up),
    .pending_down (pending_down)
  );

  typedef struct {
    int floor;
    int dir;
  } req_t;

  req_t exp_q[$];
  int   pulse_t[$];
  int   vectors;
  int   miscompares;
  int   cyc;
  req_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every strobe is matched against the oldest expected request.
  always @(negedge clk) begin
    if (!reset && valid_out) begin
      pulse_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("req_floor", int'(req_floor), mon_e.floor);
        check("direction", int'(direction), mon_e.dir);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input int floor, input int dir);
    req_t r;
    r.floor = floor;
    r.dir   = dir;
    exp_q.push_back(r);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    step();
    check({tag, "_valid"},   int'(valid_out),    0);
    check({tag, "_floor"},   int'(req_floor),    0);
    check({tag, "_dir"},     int'(direction),    0);
    check({tag, "_pend_up"}, int'(pending_up),   0);
    check({tag, "_pend_dn"}, int'(pending_down), 0);
    reset = 1'b0;
    pulse_t.delete();
  endtask

  task automatic drain(input string tag, input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) step();
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic settle(input string tag, input int cycles);
    repeat (cycles) step();
    check({tag, "_idle_up"}, int'(pending_up),   0);
    check({tag, "_idle_dn"}, int'(pending_down), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    reset       = 1'b1;
    btn_up      = '0;
    btn_down    = '0;
    step();
    do_reset("rst0");

    // Clean press on floor 3 up.
    push_exp(3, 1);
    btn_up[3] = 1'b1;
    for (int n = 0; n < 60 && !pending_up[3]; n++) step();
    check("clean_pend_set", int'(pending_up[3]), 1);
    step();
    check("clean_issue_latency", int'(valid_out), 1);
    check("clean_pend_in_issue", int'(pending_up[3]), 1);
    step();
    check("clean_pend_cleared", int'(pending_up[3]), 0);
    repeat (25) step();
    btn_up[3] = 1'b0;
    drain("clean", 40);
    settle("clean", 30);

    // Bouncing down call at floor 5, then a solid hold.
    push_exp(5, 0);
    for (int seg = 0; seg < 10; seg++) begin
      btn_down[5] = (seg % 2 == 0);
      repeat (3) step();
    end
    btn_down[5] = 1'b1;
    repeat (40) step();
    btn_down[5] = 1'b0;
    drain("bounce", 40);
    settle("bounce", 30);

    // Merge: down 5 is re-pressed while it is still queued behind 11 calls.
    do_reset("rst1");
    for (int f = 0; f < 7; f++) push_exp(f, 1);
    for (int f = 1; f < 8; f++) push_exp(f, 0);
    btn_up   = 8'h7F;
    btn_down = 8'hFE;
    for (int n = 0; n < 60 && !pending_down[5]; n++) step();
    check("merge_first_pend", int'(pending_down[5]), 1);
    btn_up   = '0;
    btn_down = '0;
    repeat (20) step();
    btn_down[5] = 1'b1;
    repeat (18) step();
    check("merge_still_pend", int'(pending_down[5]), 1);
    drain("merge", 100);
    btn_down[5] = 1'b0;
    settle("merge", 40);

    // Round robin from ptr=0 with three simultaneous presses.
    do_reset("rst2");
    push_exp(1, 1);
    push_exp(6, 1);
    push_exp(2, 0);
    btn_up[1]   = 1'b1;
    btn_up[6]   = 1'b1;
    btn_down[2] = 1'b1;
    drain("rr", 80);
    btn_up   = '0;
    btn_down = '0;
    check("rr_pulse_count", pulse_t.size(), 3);
    if (pulse_t.size() == 3) begin
      check("rr_gap1", pulse_t[1] - pulse_t[0], 4);
      check("rr_gap2", pulse_t[2] - pulse_t[1], 4);
    end
    settle("rr", 30);

    // Nonexistent calls are ignored.
    btn_down[0] = 1'b1;
    btn_up[7]   = 1'b1;
    repeat (100) step();
    check("mask_pend_dn0", int'(pending_down[0]), 0);
    check("mask_pend_up7", int'(pending_up[7]), 0);
    btn_down[0] = 1'b0;
    btn_up[7]   = 1'b0;
    settle("mask", 20);

    // Press event coinciding with the issue cycle of the same call.
    push_exp(4, 1);
    push_exp(4, 1);
    btn_up[4] = 1'b1;
    for (int n = 0; n < 60 && !(valid_out && req_floor == 3'd4); n++) step();
    check("setwin_first_issue", int'(valid_out), 1);
    force dut.press_vec = 16'h0010;
    @(posedge clk);
    #1;
    release dut.press_vec;
    step();
    check("setwin_pend_kept", int'(pending_up[4]), 1);
    drain("setwin", 40);
    btn_up[4] = 1'b0;
    settle("setwin", 30);

    // Reset while in HOLDOFF with three calls still pending.
    do_reset("rst3");
    push_exp(2, 1);
    btn_up[2]   = 1'b1;
    btn_up[5]   = 1'b1;
    btn_down[3] = 1'b1;
    btn_down[7] = 1'b1;
    drain("midrst", 60);
    step();
    check("midrst_pend_up", int'(pending_up),   8'h20);
    check("midrst_pend_dn", int'(pending_down), 8'h88);
    btn_up   = '0;
    btn_down = '0;
    do_reset("midrst");
    pulse_t.delete();
    repeat (60) step();
    check("midrst_no_pulse", pulse_t.size(), 0);
    check("midrst_pend_up_end", int'(pending_up),   0);
    check("midrst_pend_dn_end", int'(pending_down), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
